// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave backed by NUM_REGS 32-bit registers at byte address 4*i.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_slave_regfile #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t             r_wstate;
    rstate_t             r_rstate;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_awready, r_wready, r_arready;
    logic                r_aw_got, r_w_got;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_bvalid, r_rvalid;
    logic [1:0]          r_bresp, r_rresp;
    logic [DATA_W-1:0]   r_rdata;

    // A channel beat is taken either from its latch (arrived earlier) or straight off the bus.
    logic                w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic [IDX_W-1:0]    w_widx, w_ridx;
    logic                w_win, w_rin;

    assign w_aw_hs   = awvalid & r_awready;
    assign w_w_hs    = wvalid & r_wready;
    assign w_aw_have = r_aw_got | w_aw_hs;
    assign w_w_have  = r_w_got | w_w_hs;
    assign w_waddr   = r_aw_got ? r_awaddr : awaddr;
    assign w_wdata   = r_w_got ? r_wdata : wdata;
    assign w_wstrb   = r_w_got ? r_wstrb : wstrb;
    assign w_widx    = w_waddr[2 +: IDX_W];
    assign w_win     = (w_waddr < ADDR_LIMIT);
    assign w_ridx    = araddr[2 +: IDX_W];
    assign w_rin     = (araddr < ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_have && w_w_have) begin
                        if (w_win) begin
                            for (int b = 0; b < STRB_W; b++)
                                if (w_wstrb[b]) r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                        r_bresp   <= w_win ? RESP_OKAY : RESP_OOR;
                        r_bvalid  <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (w_aw_hs) r_awaddr <= awaddr;
                        if (w_w_hs) begin
                            r_wdata <= wdata;
                            r_wstrb <= wstrb;
                        end
                        r_aw_got  <= w_aw_have;
                        r_w_got   <= w_w_have;
                        r_awready <= ~w_aw_have;
                        r_wready  <= ~w_w_have;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read samples the register array before any same-edge write lands, so it sees the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_rdata   <= w_rin ? r_regs[w_ridx] : '0;
                        r_rresp   <= w_rin ? RESP_OKAY : RESP_OOR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_RESP;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile; expected B/R responses are queued
// by the stimulus and checked by an independent monitor on each handshake.
module tb_axi_lite_slave_regfile;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    axi_lite_slave_regfile #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expectation on every B/R handshake; reset discards anything pending.
    always @(negedge clk) begin
        if (!rst) begin
            exp_b.delete();
            exp_r.delete();
        end else begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", {62'd0, bresp}, {62'd0, exp_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else chk("rdata_rresp", {30'd0, rresp, rdata}, {30'd0, exp_r.pop_front()});
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_delay, input logic [1:0] er);
        int  cyc = 0;
        bit  awd = 0, wd = 0, hs_aw, hs_w;
        exp_b.push_back(er);
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = d; wstrb = s;
        if (aw_delay == 0) begin awvalid = 1'b1; awaddr = a; end
        while (!(awd && wd) && cyc < 50) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (hs_aw) begin awvalid = 1'b0; awd = 1; end
            if (hs_w)  begin wvalid = 1'b0;  wd = 1; end
            if (!awd && cyc >= aw_delay) begin awvalid = 1'b1; awaddr = a; end
            if (!(awd && wd)) chk("b_early", {63'd0, bvalid}, 0);
            if (wd && !awd) chk("wready_after_w", {63'd0, wready}, 0);
        end
        if (!(awd && wd)) begin
            chk("write_timeout", 1, 0);
            awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            chk("b_latency", {63'd0, bvalid}, 1);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int cyc = 0;
        bit done = 0, hs;
        exp_r.push_back({er, ed});
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a;
        while (!done && cyc < 50) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        if (!done) begin
            chk("read_timeout", 1, 0);
            arvalid = 1'b0;
        end else begin
            chk("r_latency", {63'd0, rvalid}, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: outputs idle low, readies rise one edge after release.
        @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {bvalid, rvalid, awready, wready, arready, bresp, rresp, rdata}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", {61'd0, awready, wready, arready}, 0);
        @(posedge clk); #1;
        chk("ready_after_release", {61'd0, awready, wready, arready}, 3'b111);
        axi_read(32'h18, 32'h0, 2'b00);

        // Full write, then read back.
        axi_write(32'h18, 32'hAABBCCDD, 4'hF, 0, 2'b00);
        axi_read(32'h18, 32'hAABBCCDD, 2'b00);

        // W leads AW by three cycles, unaligned address, partial strobes.
        axi_write(32'h1A, 32'h12345678, 4'b0101, 3, 2'b00);
        axi_read(32'h18, 32'hAA34CC78, 2'b00);

        // Same-edge write commit and read of reg 6: read sees the old value.
        fork
            axi_write(32'h18, 32'h55667788, 4'hF, 0, 2'b00);
            axi_read(32'h18, 32'hAA34CC78, 2'b00);
        join
        axi_read(32'h18, 32'h55667788, 2'b00);

        // Backpressure on both response channels.
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        fork
            axi_write(32'h0C, 32'h0BADF00D, 4'hF, 0, 2'b00);
            axi_read(32'h18, 32'h55667788, 2'b00);
        join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valids", {62'd0, bvalid, rvalid}, 2'b11);
            chk("bp_rdata", {30'd0, rresp, rdata}, {30'd0, 2'b00, 32'h55667788});
            chk("bp_bresp", {62'd0, bresp}, 0);
            chk("bp_readies", {62'd0, awready, arready}, 0);
        end
        @(posedge clk); #1;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {60'd0, awready, arready, bvalid, rvalid}, 4'b1100);
        axi_read(32'h0C, 32'h0BADF00D, 2'b00);

        // Out-of-range write must not alias onto reg 0.
        axi_write(32'h0, 32'h13579BDF, 4'hF, 0, 2'b00);
        axi_write(32'h101, 32'h12345678, 4'hF, 0, OOR);
        axi_read(32'h101, 32'h0, OOR);
        axi_read(32'h0, 32'h13579BDF, 2'b00);

        // Reset while a B response is pending.
        @(posedge clk); #1;
        bready = 1'b0;
        axi_write(32'h18, 32'hDEADBEEF, 4'hF, 0, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_drop", {61'd0, bvalid, awready, wready}, 0);
        @(posedge clk); #1;
        rst = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", {61'd0, awready, wready, arready}, 3'b111);
        axi_read(32'h18, 32'h0, 2'b00);
        axi_read(32'h0C, 32'h0, 2'b00);
        axi_read(32'h00, 32'h0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_b", exp_b.size(), 0);
        chk("pending_r", exp_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
